// File: rtl/cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_ctrl
// Description : Line-fill / write-back controller; serialises 4-word cache
//               line requests onto a single-word synchronous SRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_rw,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [4*WORD_W-1:0]   req_data,
    output logic                  mem_ready,
    output logic [4*WORD_W-1:0]   mem_rdata,
    output logic                  busy,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic                  sram_we,
    output logic [WORD_W-1:0]     sram_wdata,
    input  logic [WORD_W-1:0]     sram_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               r_cnt;
    logic                     r_drain;
    logic [ADDR_W-3:0]        r_line_addr;
    logic [3:0][WORD_W-1:0]   r_line;
    logic [4*WORD_W-1:0]      r_rdata;
    logic                     w_accept;
    logic                     w_unused;

    assign w_accept = req_valid && ((r_state == c_IDLE) || (r_state == c_RESP));
    assign w_unused = &{1'b0, req_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 2'd0;
            r_drain     <= 1'b0;
            r_line_addr <= '0;
            r_line      <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_RESP: begin
                    if (w_accept) begin
                        r_state     <= req_rw ? c_WRITE : c_READ;
                        r_line_addr <= req_addr[ADDR_W-1:2];
                        r_line      <= req_data;
                        r_cnt       <= 2'd0;
                        r_drain     <= 1'b0;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_WRITE: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= c_RESP;
                    end
                end
                c_READ: begin
                    // SRAM data trails its address by one cycle, so the
                    // word landing now belongs to the previous beat.
                    if (r_drain) begin
                        r_rdata <= {sram_rdata, r_line[2], r_line[1], r_line[0]};
                        r_drain <= 1'b0;
                        r_state <= c_RESP;
                    end else begin
                        if (r_cnt != 2'd0) begin
                            r_line[r_cnt - 2'd1] <= sram_rdata;
                        end
                        if (r_cnt == 2'd3) begin
                            r_drain <= 1'b1;
                        end
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign mem_ready  = (r_state == c_RESP);
    assign busy       = (r_state != c_IDLE);
    assign sram_we    = (r_state == c_WRITE);
    assign sram_addr  = {r_line_addr, r_cnt};
    assign sram_wdata = r_line[r_cnt];
    assign mem_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_ctrl
// Description : Self-checking bench for cache_mem_ctrl with SRAM model,
//               directed vector table and randomised line traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_rw;
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        busy;
    logic [15:0] sram_addr;
    logic        sram_we;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] last_rd = '0;

    always #5 clk = ~clk;

    cache_mem_ctrl #(.ADDR_W(16), .WORD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Background contents of never-written SRAM words.
    function automatic logic [15:0] pat(input logic [15:0] a);
        if (a >= 16'h0080 && a <= 16'h0083) return 16'((a - 16'h007F) * 16'h1111);
        return a ^ 16'hA5C3;
    endfunction

    logic [15:0] sram [0:65535];
    bit          sram_wr [0:65535];
    always @(posedge clk) begin
        if (sram_we) begin
            sram[sram_addr]    <= sram_wdata;
            sram_wr[sram_addr] <= 1'b1;
        end
        sram_rdata <= sram_wr[sram_addr] ? sram[sram_addr] : pat(sram_addr);
    end

    // Reference model: whole lines keyed by line base address.
    logic [63:0] ref_lines [int];
    function automatic logic [63:0] ref_line(input logic [15:0] a);
        logic [15:0] b;
        b = {a[15:2], 2'b00};
        if (ref_lines.exists(int'(b))) return ref_lines[int'(b)];
        return {pat(b + 16'd3), pat(b + 16'd2), pat(b + 16'd1), pat(b)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input bit rw, input logic [15:0] addr, input logic [63:0] data);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_data  = data;
    endtask

    // Follows a request issued at the current negedge through to its
    // mem_ready cycle; returns positioned at that cycle's negedge.
    task automatic run_txn(input bit rw, input logic [15:0] addr, input logic [63:0] data,
                           input logic [63:0] exp, input int inj);
        logic [15:0] base;
        int          n;
        base = {addr[15:2], 2'b00};
        n    = rw ? 4 : 5;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            req_valid = (c == inj);
            if (c == inj) begin
                req_rw   = 1'b0;
                req_addr = 16'h0300;
            end
            chk("busy_beat", busy, 1);
            chk("ready_early", mem_ready, 0);
            chk("we_beat", sram_we, (rw && c <= 4) ? 1 : 0);
            if (c <= 4) chk("beat_addr", sram_addr, 16'(base + 16'(c - 1)));
            if (rw) chk("beat_wdata", sram_wdata, data[16*(c-1) +: 16]);
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("ready", mem_ready, 1);
        chk("busy_resp", busy, 1);
        chk("we_resp", sram_we, 0);
        if (!rw) begin
            chk("rdata", mem_rdata, exp);
            last_rd = exp;
        end else begin
            ref_lines[int'(base)] = data;
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_ready", mem_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_we", sram_we, 0);
        chk("rdata_held", mem_rdata, last_rd);
    endtask

    typedef struct {
        bit          rw;
        logic [15:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
        bit          chain;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] lines [8];
        bit          rw;
        logic [15:0] addr;
        logic [63:0] data;

        tbl[0] = '{1'b1, 16'h0043, 64'hDDDD_CCCC_BBBB_AAAA, 64'h0, 1'b0};
        tbl[1] = '{1'b0, 16'h0082, 64'h0, 64'h4444_3333_2222_1111, 1'b0};
        tbl[2] = '{1'b0, 16'h0041, 64'h0, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0};
        tbl[3] = '{1'b1, 16'h0100, 64'h1357_9BDF_2468_ACE0, 64'h0, 1'b1};
        tbl[4] = '{1'b0, 16'h0200, 64'h0, 64'hA7C0_A7C1_A7C2_A7C3, 1'b0};
        tbl[5] = '{1'b1, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1};
        tbl[6] = '{1'b0, 16'hFFFE, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
        tbl[7] = '{1'b0, 16'h0103, 64'h0, 64'h1357_9BDF_2468_ACE0, 1'b0};

        // Reset with a simultaneous request: reset must win.
        rst = 1'b1;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0010; req_data = '1;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        chk("rst_ready", mem_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rdata", mem_rdata, 0);
        rst = 1'b0;
        idle_check();

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].rw, tbl[i].addr, tbl[i].data);
            run_txn(tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].exp, 0);
            if (!tbl[i].chain) idle_check();
        end

        // Request arriving during the second write beat is ignored.
        issue(1'b1, 16'h0500, 64'hFEED_FACE_CAFE_BEEF);
        run_txn(1'b1, 16'h0500, 64'hFEED_FACE_CAFE_BEEF, 64'h0, 2);
        idle_check();
        idle_check();

        // Reset in the middle of a read aborts it without a completion.
        issue(1'b0, 16'h0080, 64'h0);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_ready", mem_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_we", sram_we, 0);
        chk("abort_addr", sram_addr, 0);
        chk("abort_wdata", sram_wdata, 0);
        chk("abort_rdata", mem_rdata, 0);
        last_rd = '0;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) idle_check();

        lines = '{16'h0000, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h1234, 16'h8000, 16'hFFFC};
        for (int k = 0; k < 40; k++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = {lines[$urandom_range(0, 7)][15:2], 2'($urandom_range(0, 3))};
            data = {$urandom, $urandom};
            issue(rw, addr, data);
            run_txn(rw, addr, data, rw ? 64'h0 : ref_line(addr), 0);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Line-fill / write-back memory controller sitting directly downstream of the direct-mapped cache controller. Accepts one-cycle line requests (64-bit line, 4 × 16-bit words) from the cache's memory-request port, serialises them into 4 single-word beats on a 16-bit synchronous SRAM port, and returns a one-cycle `mem_ready` pulse (with the assembled line for reads). Handles the cache's write-back-then-allocate sequence, including a new request presented in the same cycle as `mem_ready`.

## Interface
- `ADDR_W`, 16, word-address width (request and SRAM).
- `WORD_W`, 16, SRAM word width; line width is 4×`WORD_W`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request strobe; may be high for a single cycle only.
- `req_rw`  in  1  1 = write line (write-back), 0 = read line (allocate).
- `req_addr`  in  ADDR_W  word address; bits [1:0] ignored (line-aligned).
- `req_data`  in  4×WORD_W  write line; word i at [16i+15:16i].
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  4×WORD_W  read line; valid with `mem_ready` of a read, held until next read completes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sram_addr`  out  ADDR_W  SRAM word address.
- `sram_we`  out  1  SRAM write enable.
- `sram_wdata`  out  WORD_W  SRAM write data.
- `sram_rdata`  in  WORD_W  SRAM read data, valid exactly 1 cycle after address presented with `sram_we`=0.

## Operation
- States: IDLE, WRITE, READ, RESP.
- Request latch: on acceptance, register `req_rw`, `{req_addr[ADDR_W-1:2],2'b00}`, `req_data`; beat counter ← 0. Inputs are not sampled again until next acceptance.
- Acceptance: in IDLE or RESP when `req_valid`=1. IDLE→WRITE (rw=1) or READ (rw=0); RESP→same. RESP with no request → IDLE.
- `req_valid` in WRITE or READ: ignored, no state effect.
- WRITE: each cycle drive `sram_we`=1, `sram_addr`=base+cnt, `sram_wdata`=line word cnt; cnt 0..3; after cnt=3 → RESP.
- READ: each cycle drive `sram_we`=0, `sram_addr`=base+cnt for cnt 0..3; capture `sram_rdata` into line word (cnt−1) the following cycle; fourth word captured in the cycle after cnt=3 (one drain cycle, no address issued, `sram_we`=0); then → RESP.
- RESP: `mem_ready`=1 for exactly this cycle; for reads, `mem_rdata` updated to full line in same cycle as pulse.
- Address arithmetic: base+cnt never carries out of the line (base[1:0]=0); top line of address space valid.
- `sram_addr`/`sram_wdata` are don't-care when not in a beat; `sram_we` is 0 outside WRITE beats.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `busy`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, beat counter 0.
- Request accepted at edge T (valid high in cycle T).
- Write: beats in cycles T+1..T+4, `mem_ready` in T+5. Latency 5.
- Read: addresses in T+1..T+4, drain T+5, `mem_ready` + `mem_rdata` in T+6. Latency 6.
- Back-to-back: request in RESP cycle R starts first beat at R+1; no IDLE bubble (write-back→allocate = 5+6 cycles).
- Reset mid-operation: next edge with `rst`=1 aborts; `sram_we` low from that edge; no `mem_ready` for aborted request; SRAM words already written stay written.
- `rst` and `req_valid` in same cycle: reset wins, request dropped.

## Test plan
- Reset: hold `rst` 2 cycles mid-READ -> all outputs at reset values next cycle, no `mem_ready`, `busy`=0.
- Write: valid 1 cycle, rw=1, addr 0x0043, data 0xDDDD_CCCC_BBBB_AAAA -> `sram_we` high T+1..T+4 at 0x0040..0x0043 with AAAA,BBBB,CCCC,DDDD; `mem_ready` at T+5 only.
- Read: SRAM model holds 0x0080..0x0083 = 1111,2222,3333,4444; read addr 0x0082 -> `mem_ready` at T+6, `mem_rdata`=0x4444_3333_2222_1111, held after pulse.
- Write-back then allocate: write 0x0100 then read 0x0200 asserted in the write's `mem_ready` cycle -> read beats begin next cycle, read `mem_ready` 6 cycles after write `mem_ready`.
- Ignored request: second `req_valid` (rw=0, 0x0300) during WRITE beat 2 -> no change in beat sequence or addresses; single `mem_ready`; returns to IDLE.
- Top-of-space: read 0xFFFF -> addresses 0xFFFC..0xFFFF, no wrap to 0x0000.
